// File: rtl/cpu_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder_pkg
// Shared types and constants for the CPU bus responder: bus widths, response
// codes, access-size codes, FSM state encoding, grant encoding and the
// alignment check used by the request decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_bus_responder_pkg;

  localparam int INST_BUS = 32;  // fetch data width
  localparam int DATA_BUS = 64;  // load/store and backend beat width
  localparam int STRB_W   = DATA_BUS / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // An access is misaligned when the low address bits are not a multiple
  // of the access size (2^size bytes).
  function automatic logic is_misaligned(input logic [2:0] offset, input size_e size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder_if
// Bundles the core-side fetch port (if_*), the core-side data port (mem_*)
// and the backend RAM request/response channel (ram_*).
//   modport slave  : the responder's view (core requests in, RAM requests out)
//   modport master : the environment's view (core + RAM model)
// Parameter ADDR_W : address width on both core ports and on the backend.
// -----------------------------------------------------------------------------
interface cpu_bus_responder_if
  import cpu_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 64
) ();

  // Fetch port
  logic                if_valid;
  logic [ADDR_W-1:0]   if_addr;
  logic [1:0]          if_size;
  logic                if_req;
  logic                if_ready;
  logic [INST_BUS-1:0] if_data_read;
  logic [1:0]          if_resp;

  // Data port
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [1:0]          mem_size;
  logic                mem_req;
  logic [DATA_BUS-1:0] mem_data_write;
  logic                mem_ready;
  logic [DATA_BUS-1:0] mem_data_read;
  logic [1:0]          mem_resp;

  // Backend RAM channel
  logic                ram_req_valid;
  logic                ram_req_ready;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_wen;
  logic [DATA_BUS-1:0] ram_wdata;
  logic [STRB_W-1:0]   ram_wstrb;
  logic                ram_rsp_valid;
  logic [DATA_BUS-1:0] ram_rdata;
  logic                ram_rsp_err;

  modport slave (
    input  if_valid, if_addr, if_size, if_req,
    output if_ready, if_data_read, if_resp,
    input  mem_valid, mem_addr, mem_size, mem_req, mem_data_write,
    output mem_ready, mem_data_read, mem_resp,
    output ram_req_valid, ram_addr, ram_wen, ram_wdata, ram_wstrb,
    input  ram_req_ready, ram_rsp_valid, ram_rdata, ram_rsp_err
  );

  modport master (
    output if_valid, if_addr, if_size, if_req,
    input  if_ready, if_data_read, if_resp,
    output mem_valid, mem_addr, mem_size, mem_req, mem_data_write,
    input  mem_ready, mem_data_read, mem_resp,
    input  ram_req_valid, ram_addr, ram_wen, ram_wdata, ram_wstrb,
    output ram_req_ready, ram_rsp_valid, ram_rdata, ram_rsp_err
  );

endinterface

// File: rtl/cpu_bus_responder_bus_lane_align.sv
// -----------------------------------------------------------------------------
// bus_lane_align
// Purely combinational byte-lane steering between an LSB-aligned core view
// and the 8-byte-aligned backend beat.
//   size      in  2   access size code (B/H/W/D)
//   offset    in  3   byte offset within the beat (addr[2:0])
//   wdata_in  in  64  LSB-aligned store data
//   rdata_in  in  64  backend read beat
//   wstrb     out 8   byte strobes for the beat
//   wdata_out out 64  store data moved to its byte lanes
//   rdata_out out 64  read beat moved down to LSB (upper bytes not masked)
// -----------------------------------------------------------------------------
module bus_lane_align
  import cpu_bus_responder_pkg::*;
(
  input  size_e               size,
  input  logic [2:0]          offset,
  input  logic [DATA_BUS-1:0] wdata_in,
  input  logic [DATA_BUS-1:0] rdata_in,
  output logic [STRB_W-1:0]   wstrb,
  output logic [DATA_BUS-1:0] wdata_out,
  output logic [DATA_BUS-1:0] rdata_out
);

  logic [STRB_W-1:0] base_strb;
  logic [5:0]        bit_shift;

  always_comb begin
    case (size)
      SIZE_B:  base_strb = 8'h01;
      SIZE_H:  base_strb = 8'h03;
      SIZE_W:  base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
    bit_shift = {offset, 3'b000};
    wstrb     = base_strb << offset;
    wdata_out = wdata_in << bit_shift;
    rdata_out = rdata_in >> bit_shift;
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
// Slave-side responder for the core's fetch and data ports. Arbitrates
// (data port has fixed priority), turns each accepted request into one
// single-beat backend RAM transaction, and returns data, a one-cycle ready
// pulse and a response code to the granted port. Misaligned requests and
// fetches that are not word-sized complete immediately with SLVERR and never
// touch the backend.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    cpu_bus_responder_if.slave (if_*, mem_*, ram_* signals)
// Parameters:
//   ADDR_W          address width (core ports and backend)
//   TIMEOUT_CYCLES  WAIT cycles before a DECERR watchdog response
// Optional feature macro: CPU_BUS_TIMEOUT_EN -- when defined, a watchdog ends
// a stuck WAIT with DECERR and zero data; otherwise WAIT has no limit.
// -----------------------------------------------------------------------------
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clock,
  input logic                reset,
  cpu_bus_responder_if.slave bus
);

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  size_e               size_q, size_d;
  logic                wen_q, wen_d;
  logic [DATA_BUS-1:0] wdata_q, wdata_d;
  logic [INST_BUS-1:0] if_data_q, if_data_d;
  logic [1:0]          if_resp_q, if_resp_d;
  logic [DATA_BUS-1:0] mem_data_q, mem_data_d;
  logic [1:0]          mem_resp_q, mem_resp_d;

  logic                load_rsp;
  resp_e               rsp_code;
  logic [DATA_BUS-1:0] rsp_data;
  logic                req_err;

  logic [STRB_W-1:0]   lane_wstrb;
  logic [DATA_BUS-1:0] lane_wdata;
  logic [DATA_BUS-1:0] lane_rdata;

  // Fetches are always reads, so the fetch direction bit carries no information.
  logic unused_if_req;
  assign unused_if_req = bus.if_req;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  // Without the watchdog the timeout length has no effect.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  bus_lane_align u_lane_align (
    .size      (size_q),
    .offset    (addr_q[2:0]),
    .wdata_in  (wdata_q),
    .rdata_in  (bus.ram_rdata),
    .wstrb     (lane_wstrb),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  // Arbitration, request capture and FSM next state.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned -- that is what keeps always_comb from inferring latches.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    load_rsp = 1'b0;
    rsp_code = RESP_OKAY;
    rsp_data = '0;
    req_err  = 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          grant_d = GRANT_MEM;
          addr_d  = bus.mem_addr;
          size_d  = size_e'(bus.mem_size);
          wen_d   = bus.mem_req;
          wdata_d = bus.mem_data_write;
          req_err = is_misaligned(bus.mem_addr[2:0], size_e'(bus.mem_size));
        end else if (bus.if_valid) begin
          grant_d = GRANT_IF;
          addr_d  = bus.if_addr;
          size_d  = size_e'(bus.if_size);
          wen_d   = 1'b0;
          wdata_d = '0;
          req_err = (size_e'(bus.if_size) != SIZE_W) ||
                    is_misaligned(bus.if_addr[2:0], SIZE_W);
        end
        if (bus.mem_valid || bus.if_valid) begin
          if (req_err) begin
            // Rejected requests skip the backend entirely.
            state_d  = ST_RESP;
            load_rsp = 1'b1;
            rsp_code = RESP_SLVERR;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (bus.ram_req_ready) begin
          state_d = ST_WAIT;
`ifdef CPU_BUS_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      ST_WAIT: begin
`ifdef CPU_BUS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        if (bus.ram_rsp_valid) begin
          state_d  = ST_RESP;
          load_rsp = 1'b1;
          rsp_code = bus.ram_rsp_err ? RESP_SLVERR : RESP_OKAY;
          rsp_data = lane_rdata;
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up; a response arriving later lands in IDLE and is ignored.
          state_d  = ST_RESP;
          load_rsp = 1'b1;
          rsp_code = RESP_DECERR;
          rsp_data = '0;
        end
`endif
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers: only the granted port's data/resp change, and they
  // hold until that port's next completion.
  always_comb begin
    if_data_d  = if_data_q;
    if_resp_d  = if_resp_q;
    mem_data_d = mem_data_q;
    mem_resp_d = mem_resp_q;
    if (load_rsp) begin
      if (grant_d == GRANT_MEM) begin
        mem_data_d = rsp_data;
        mem_resp_d = rsp_code;
      end else begin
        if_data_d = rsp_data[INST_BUS-1:0];
        if_resp_d = rsp_code;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_IF;
      addr_q     <= '0;
      size_q     <= SIZE_B;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      if_resp_q  <= '0;
      mem_data_q <= '0;
      mem_resp_q <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      if_resp_q  <= if_resp_d;
      mem_data_q <= mem_data_d;
      mem_resp_q <= mem_resp_d;
`ifdef CPU_BUS_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Backend request fields are only presented while the request is offered.
  logic in_req;
  assign in_req = (state_q == ST_REQ);

  assign bus.ram_req_valid = in_req;
  assign bus.ram_addr      = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.ram_wen       = in_req & wen_q;
  assign bus.ram_wdata     = (in_req && wen_q) ? lane_wdata : '0;
  assign bus.ram_wstrb     = (in_req && wen_q) ? lane_wstrb : '0;

  assign bus.if_ready      = (state_q == ST_RESP) && (grant_q == GRANT_IF);
  assign bus.mem_ready     = (state_q == ST_RESP) && (grant_q == GRANT_MEM);
  assign bus.if_data_read  = if_data_q;
  assign bus.if_resp       = if_resp_q;
  assign bus.mem_data_read = mem_data_q;
  assign bus.mem_resp      = mem_resp_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_responder
// Directed, table-driven bench for cpu_bus_responder: a vector table of single
// transactions (aligned loads/stores/fetches and rejected requests) followed by
// hand-written sequences for arbitration, backend stall, reset in WAIT and,
// when CPU_BUS_TIMEOUT_EN is defined, the watchdog.
// -----------------------------------------------------------------------------
module tb_cpu_bus_responder;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  cpu_bus_responder_if #(.ADDR_W(64)) bus ();

  cpu_bus_responder #(.ADDR_W(64), .TIMEOUT_CYCLES(255)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mem;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rsp_err;
    logic        err_path;
    logic [63:0] exp_ram_addr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic        chk_data;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid       = 1'b0;
    bus.if_addr        = '0;
    bus.if_size        = 2'b00;
    bus.if_req         = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_size       = 2'b00;
    bus.mem_req        = 1'b0;
    bus.mem_data_write = '0;
    bus.ram_req_ready  = 1'b1;
    bus.ram_rsp_valid  = 1'b0;
    bus.ram_rdata      = '0;
    bus.ram_rsp_err    = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if (v.is_mem) begin
      bus.mem_valid      = 1'b1;
      bus.mem_addr       = v.addr;
      bus.mem_size       = v.size;
      bus.mem_req        = v.wr;
      bus.mem_data_write = v.wdata;
    end else begin
      bus.if_valid = 1'b1;
      bus.if_addr  = v.addr;
      bus.if_size  = v.size;
      bus.if_req   = 1'b0;
    end
    tick();  // cycle 1
    if (v.err_path) begin
      check($sformatf("v%0d err ready", idx), v.is_mem ? bus.mem_ready : bus.if_ready, 1);
      check($sformatf("v%0d err resp", idx), v.is_mem ? bus.mem_resp : bus.if_resp, 2'b10);
      check($sformatf("v%0d no ram req", idx), bus.ram_req_valid, 0);
      bus.mem_valid = 1'b0;
      bus.if_valid  = 1'b0;
      tick();
      check($sformatf("v%0d err ready drop", idx), v.is_mem ? bus.mem_ready : bus.if_ready, 0);
      check($sformatf("v%0d no ram req later", idx), bus.ram_req_valid, 0);
    end else begin
      check($sformatf("v%0d req valid", idx), bus.ram_req_valid, 1);
      check($sformatf("v%0d ram addr", idx), bus.ram_addr, v.exp_ram_addr);
      check($sformatf("v%0d ram wen", idx), bus.ram_wen, v.wr);
      if (v.wr) begin
        check($sformatf("v%0d wstrb", idx), bus.ram_wstrb, v.exp_wstrb);
        check($sformatf("v%0d wdata", idx), bus.ram_wdata, v.exp_wdata);
      end
      check($sformatf("v%0d early ready", idx), v.is_mem ? bus.mem_ready : bus.if_ready, 0);
      tick();  // cycle 2, WAIT
      check($sformatf("v%0d req dropped", idx), bus.ram_req_valid, 0);
      bus.ram_rsp_valid = 1'b1;
      bus.ram_rdata     = v.rdata;
      bus.ram_rsp_err   = v.rsp_err;
      tick();  // cycle 3, RESP
      bus.ram_rsp_valid = 1'b0;
      bus.ram_rsp_err   = 1'b0;
      check($sformatf("v%0d ready", idx), v.is_mem ? bus.mem_ready : bus.if_ready, 1);
      check($sformatf("v%0d other ready", idx), v.is_mem ? bus.if_ready : bus.mem_ready, 0);
      check($sformatf("v%0d resp", idx), v.is_mem ? bus.mem_resp : bus.if_resp, v.exp_resp);
      if (v.chk_data)
        check($sformatf("v%0d data", idx),
              v.is_mem ? bus.mem_data_read : {32'h0, bus.if_data_read}, v.exp_data);
      bus.mem_valid = 1'b0;
      bus.if_valid  = 1'b0;
      tick();
      check($sformatf("v%0d ready pulse", idx), v.is_mem ? bus.mem_ready : bus.if_ready, 0);
      if (v.chk_data)
        check($sformatf("v%0d data hold", idx),
              v.is_mem ? bus.mem_data_read : {32'h0, bus.if_data_read}, v.exp_data);
    end
  endtask

  initial begin
    // is_mem addr size wr wdata rdata rsp_err err_path ram_addr wstrb wdata chk_data data resp
    vecs[0]  = '{1'b0, 64'h8000_0004, 2'b10, 1'b0, 64'h0, 64'h1111_2222_3333_4444, 1'b0, 1'b0,
                 64'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h1111_2222, 2'b00};
    vecs[1]  = '{1'b1, 64'h8000_0103, 2'b00, 1'b1, 64'hAB, 64'h0, 1'b0, 1'b0,
                 64'h8000_0100, 8'h08, 64'hAB00_0000, 1'b0, 64'h0, 2'b00};
    vecs[2]  = '{1'b1, 64'h10, 2'b11, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0,
                 64'h10, 8'h00, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[3]  = '{1'b1, 64'h8000_0006, 2'b01, 1'b0, 64'h0, 64'hAABB_CCDD_EEFF_0011, 1'b0, 1'b0,
                 64'h8000_0000, 8'h00, 64'h0, 1'b1, 64'hAABB, 2'b00};
    vecs[4]  = '{1'b1, 64'h4005, 2'b00, 1'b0, 64'h0, 64'h0807_0605_0403_0201, 1'b0, 1'b0,
                 64'h4000, 8'h00, 64'h0, 1'b1, 64'h08_0706, 2'b00};
    vecs[5]  = '{1'b1, 64'h2004, 2'b10, 1'b1, 64'hDEAD_BEEF, 64'h0, 1'b0, 1'b0,
                 64'h2000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0, 64'h0, 2'b00};
    vecs[6]  = '{1'b1, 64'h3000, 2'b11, 1'b1, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 1'b0,
                 64'h3000, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 2'b00};
    vecs[7]  = '{1'b1, 64'h4002, 2'b01, 1'b1, 64'h1234, 64'h0, 1'b0, 1'b0,
                 64'h4000, 8'h0C, 64'h1234_0000, 1'b0, 64'h0, 2'b00};
    vecs[8]  = '{1'b1, 64'h5000, 2'b10, 1'b0, 64'h0, 64'hCAFE, 1'b1, 1'b0,
                 64'h5000, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[9]  = '{1'b1, 64'h8000_0001, 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1,
                 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[10] = '{1'b1, 64'h6002, 2'b10, 1'b1, 64'h5555, 64'h0, 1'b0, 1'b1,
                 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[11] = '{1'b0, 64'h1000, 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1,
                 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[12] = '{1'b0, 64'h1002, 2'b10, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1,
                 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[13] = '{1'b1, 64'h7004, 2'b11, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1,
                 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 2'b10};
    vecs[14] = '{1'b1, 64'h9004, 2'b10, 1'b0, 64'h0, 64'hFFEE_DDCC_BBAA_9988, 1'b0, 1'b0,
                 64'h9000, 8'h00, 64'h0, 1'b1, 64'hFFEE_DDCC, 2'b00};

    // ---------------- reset state ----------------
    reset = 1'b1;
    idle_inputs();
    #12;
    check("rst if_ready", bus.if_ready, 0);
    check("rst if_data", bus.if_data_read, 0);
    check("rst if_resp", bus.if_resp, 0);
    check("rst mem_ready", bus.mem_ready, 0);
    check("rst mem_data", bus.mem_data_read, 0);
    check("rst mem_resp", bus.mem_resp, 0);
    check("rst ram_req_valid", bus.ram_req_valid, 0);
    check("rst ram_addr", bus.ram_addr, 0);
    check("rst ram_wen", bus.ram_wen, 0);
    check("rst ram_wdata", bus.ram_wdata, 0);
    check("rst ram_wstrb", bus.ram_wstrb, 0);
    reset = 1'b0;
    tick();

    // ---------------- vector table ----------------
    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // ---------------- simultaneous valids: mem first, then fetch ----------------
    bus.mem_valid = 1'b1; bus.mem_addr = 64'h200; bus.mem_size = 2'b10; bus.mem_req = 1'b0;
    bus.if_valid  = 1'b1; bus.if_addr  = 64'h100; bus.if_size  = 2'b10;
    tick();
    check("arb first req", bus.ram_req_valid, 1);
    check("arb first addr", bus.ram_addr, 64'h200);
    tick();
    bus.ram_rsp_valid = 1'b1; bus.ram_rdata = 64'h0000_0000_7777_8888;
    tick();
    bus.ram_rsp_valid = 1'b0;
    check("arb mem ready", bus.mem_ready, 1);
    check("arb if waits", bus.if_ready, 0);
    check("arb mem data", bus.mem_data_read, 64'h7777_8888);
    bus.mem_valid = 1'b0;
    tick();
    check("arb mem pulse", bus.mem_ready, 0);
    check("arb idle gap", bus.ram_req_valid, 0);
    tick();
    check("arb second req", bus.ram_req_valid, 1);
    check("arb second addr", bus.ram_addr, 64'h100);
    tick();
    bus.ram_rsp_valid = 1'b1; bus.ram_rdata = 64'h0000_0000_1357_9BDF;
    tick();
    bus.ram_rsp_valid = 1'b0;
    check("arb if ready", bus.if_ready, 1);
    check("arb mem quiet", bus.mem_ready, 0);
    check("arb if data", bus.if_data_read, 64'h1357_9BDF);
    bus.if_valid = 1'b0;
    tick();
    check("arb if pulse", bus.if_ready, 0);

    // ---------------- backend stall then error response ----------------
    bus.ram_req_ready = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 64'h8000; bus.mem_size = 2'b10; bus.mem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stall req valid c%0d", i), bus.ram_req_valid, 1);
      check($sformatf("stall addr c%0d", i), bus.ram_addr, 64'h8000);
      check($sformatf("stall no ready c%0d", i), bus.mem_ready, 0);
    end
    bus.ram_req_ready = 1'b1;
    tick();
    check("stall accepted", bus.ram_req_valid, 0);
    bus.ram_rsp_valid = 1'b1; bus.ram_rsp_err = 1'b1; bus.ram_rdata = 64'h0;
    tick();
    bus.ram_rsp_valid = 1'b0; bus.ram_rsp_err = 1'b0;
    check("stall err ready", bus.mem_ready, 1);
    check("stall err resp", bus.mem_resp, 2'b10);
    bus.mem_valid = 1'b0;
    tick();

    // ---------------- reset during WAIT, late response ignored ----------------
    bus.mem_valid = 1'b1; bus.mem_addr = 64'h9000; bus.mem_size = 2'b10; bus.mem_req = 1'b0;
    tick();
    check("rwait req", bus.ram_req_valid, 1);
    tick();
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    #1;
    check("rwait req_valid", bus.ram_req_valid, 0);
    check("rwait mem_data", bus.mem_data_read, 0);
    check("rwait mem_resp", bus.mem_resp, 0);
    check("rwait if_data", bus.if_data_read, 0);
    check("rwait mem_ready", bus.mem_ready, 0);
    #2;
    reset = 1'b0;
    bus.ram_rsp_valid = 1'b1; bus.ram_rdata = 64'hDEAD_0000_BEEF; bus.ram_rsp_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("late rsp mem_ready c%0d", i), bus.mem_ready, 0);
      check($sformatf("late rsp if_ready c%0d", i), bus.if_ready, 0);
      check($sformatf("late rsp req c%0d", i), bus.ram_req_valid, 0);
      check($sformatf("late rsp data c%0d", i), bus.mem_data_read, 0);
      check($sformatf("late rsp resp c%0d", i), bus.mem_resp, 0);
    end
    bus.ram_rsp_valid = 1'b0; bus.ram_rsp_err = 1'b0;
    run_vec(100, vecs[0]);

`ifdef CPU_BUS_TIMEOUT_EN
    // ---------------- watchdog ----------------
    begin
      int n;
      bus.mem_valid = 1'b1; bus.mem_addr = 64'hA000; bus.mem_size = 2'b10; bus.mem_req = 1'b0;
      tick();
      tick();  // first WAIT cycle
      n = 0;
      while (!bus.mem_ready && n < 400) begin
        tick();
        n++;
      end
      check("timeout latency", n, 255);
      check("timeout ready", bus.mem_ready, 1);
      check("timeout resp", bus.mem_resp, 2'b11);
      check("timeout data", bus.mem_data_read, 0);
      bus.mem_valid = 1'b0;
      tick();
      bus.ram_rsp_valid = 1'b1; bus.ram_rdata = 64'h1234;
      tick();
      bus.ram_rsp_valid = 1'b0;
      check("timeout late dropped", bus.mem_ready, 0);
      check("timeout late data", bus.mem_data_read, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
